// File: rtl/instruction_fetch.sv
// instruction_fetch: ROM prefetch stage with a small tagged FIFO and redirect flush.
// Ports:
//   clk, reset_n                       clock and asynchronous active-low reset
//   rom_address / rom_data             ROM read port (1-cycle synchronous read)
//   instr_valid/ready/data/address     head-of-FIFO handshake to the core
//   redirect / redirect_address        flush everything and restart fetch at the target
//   buffer_count                       FIFO occupancy (debug)
module instruction_fetch #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    output logic [ADDR_WIDTH-1:0]        rom_address,
    input  logic [DATA_WIDTH-1:0]        rom_data,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [DATA_WIDTH-1:0]        instr_data,
    output logic [ADDR_WIDTH-1:0]        instr_address,
    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirect_address,
    output logic [$clog2(DEPTH+1)-1:0]   buffer_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc, inflight_tag;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [PW-1:0]         head, tail, head_nx, tail_nx;
    logic [CW-1:0]         count;
    logic                  issue, push, pop;

    // Counting the in-flight read reserves its FIFO slot, so a capture never finds the FIFO full.
    assign issue = !redirect && ({1'b0, count} + (CW+1)'(inflight) < (CW+1)'(DEPTH));
    assign push = inflight && !redirect;
    assign pop = instr_valid && instr_ready && !redirect;
    assign head_nx = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
    assign tail_nx = (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_ADDRESS;
            inflight <= 1'b0;
            inflight_tag <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_address;
            inflight <= 1'b0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
                inflight_tag <= fetch_pc;
            end
            if (push) tail <= tail_nx;
            if (pop) head <= head_nx;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail] <= rom_data;
            addr_q[tail] <= inflight_tag;
        end
    end

    assign rom_address = fetch_pc;
    assign buffer_count = count;
    assign instr_valid = (count != '0);
    // Zero the outputs while empty so stale entries never leak onto the bus.
    assign instr_data = instr_valid ? data_q[head] : '0;
    assign instr_address = instr_valid ? addr_q[head] : '0;

    no_overflow: assert property (@(posedge clk) disable iff (!reset_n) push |-> count < CW'(DEPTH));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of instruction_fetch against a queue model.
module tb_instruction_fetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] rom_address;
    logic [15:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [10:0] instr_address;
    logic        redirect;
    logic [10:0] redirect_address;
    logic [2:0]  buffer_count;

    int errors = 0;
    int checks = 0;

    logic [10:0] q[$];
    logic [10:0] inf[$];
    logic [10:0] pc;

    instruction_fetch #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .DEPTH(DEPTH), .RESET_ADDRESS(11'h000)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_address(instr_address),
        .redirect(redirect),
        .redirect_address(redirect_address),
        .buffer_count(buffer_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= 16'h1000 + {5'd0, rom_address};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ea, ed;
        ea = (q.size() != 0) ? {21'd0, q[0]} : 32'd0;
        ed = (q.size() != 0) ? 32'h1000 + {21'd0, q[0]} : 32'd0;
        chk("valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
        chk("count", {29'd0, buffer_count}, q.size());
        chk("address", {21'd0, instr_address}, ea);
        chk("data", {16'd0, instr_data}, ed);
        chk("rom_address", {21'd0, rom_address}, {21'd0, pc});
    endtask

    task automatic model_reset();
        q.delete();
        inf.delete();
        pc = 11'h000;
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model, check at the next falling edge.
    task automatic step(input logic r, input logic rd, input logic [10:0] ra);
        int n, m;
        instr_ready = r;
        redirect = rd;
        redirect_address = ra;
        n = q.size();
        m = inf.size();
        if (rd) begin
            q.delete();
            inf.delete();
            pc = ra;
        end else begin
            if (n != 0 && r) void'(q.pop_front());
            if (m != 0) q.push_back(inf.pop_front());
            if (n + m < DEPTH) begin
                inf.push_back(pc);
                pc = pc + 11'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_address = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        // Streaming with ready held high
        repeat (12) step(1'b1, 1'b0, '0);
        // Back-pressure from reset, then drain
        do_reset();
        repeat (8) step(1'b0, 1'b0, '0);
        chk("full_count", {29'd0, buffer_count}, 32'd4);
        chk("stall_pc", {21'd0, rom_address}, 32'h4);
        chk("hold_data", {16'd0, instr_data}, 32'h1000);
        repeat (12) step(1'b1, 1'b0, '0);
        // Redirect while full and stalled
        repeat (8) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 11'h123);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("redir_addr", {21'd0, instr_address}, 32'h123);
        chk("redir_data", {16'd0, instr_data}, 32'h1123);
        // Wrap at the top of the address space
        step(1'b1, 1'b1, 11'h7FE);
        repeat (8) step(1'b1, 1'b0, '0);
        // Redirect together with a ready handshake, then back-to-back redirects
        step(1'b1, 1'b1, 11'h055);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("redir_rdy_addr", {21'd0, instr_address}, 32'h055);
        step(1'b1, 1'b1, 11'h010);
        step(1'b1, 1'b1, 11'h020);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("b2b_addr", {21'd0, instr_address}, 32'h020);
        // Asynchronous reset between clock edges
        repeat (5) step(1'b1, 1'b0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_count", {29'd0, buffer_count}, 32'd0);
        chk("async_rom", {21'd0, rom_address}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) step(1'b1, 1'b0, '0);
        // Random ready and redirect traffic
        repeat (400) step(1'($urandom % 2), ($urandom % 16) == 0, 11'($urandom));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Prefetch stage directly downstream of the program ROM, which has a 1-cycle synchronous read.
- Drives the ROM address, absorbs the ROM's 1-cycle read latency, and buffers fetched words in a small FIFO.
- Presents instructions, tagged with their address, to the CPU core over a valid/ready handshake.
- Supports a redirect (jump/branch/interrupt) that flushes all prefetched and in-flight words.

Parameters:
- ADDR_WIDTH, 11: ROM word-address width; the PC wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16: instruction word width.
- DEPTH, 4: prefetch FIFO entries; legal values are 2..16.
- RESET_ADDRESS, 0: first fetch address after reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rom_address  output  ADDR_WIDTH  word address to ROM; equals fetch_pc.
- rom_data  input  DATA_WIDTH  ROM read data; valid the cycle after an address is issued.
- instr_valid  output  1  head FIFO entry is valid.
- instr_ready  input  1  core accepts the head entry this cycle.
- instr_data  output  DATA_WIDTH  head instruction word.
- instr_address  output  ADDR_WIDTH  address of the head instruction word.
- redirect  input  1  flush and restart fetch at redirect_address.
- redirect_address  input  ADDR_WIDTH  new fetch address.
- buffer_count  output  clog2(DEPTH+1)  FIFO occupancy, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately while reset_n=0):
  - fetch_pc = RESET_ADDRESS, so rom_address = RESET_ADDRESS.
  - FIFO empty: count = 0, head and tail pointers = 0.
  - inflight = 0.
  - Outputs: instr_valid = 0, buffer_count = 0, instr_data = 0, instr_address = 0.
- Issue rule:
  - issue = !redirect && (count + inflight < DEPTH).
  - On issue: fetch_pc <= fetch_pc + 1 (mod 2^ADDR_WIDTH), inflight <= 1, inflight_tag <= fetch_pc.
  - Otherwise inflight <= 0 and fetch_pc holds.
  - The ROM reads every edge regardless; only tagged reads are used.
- Capture: in any cycle with inflight = 1 and no redirect, {rom_data, inflight_tag} is pushed at the next edge.
- Overflow: the issue rule guarantees the FIFO never overflows. Pushing into a full FIFO is a design error; an assertion must flag it.
- Pop: occurs when instr_valid && instr_ready && !redirect. Push and pop in the same cycle leave count unchanged.
- Output: instr_valid = (count != 0). instr_data and instr_address come from the head entry and are stable while valid && !ready.
- Latency:
  - Address issued in cycle N → word is in the FIFO and visible in cycle N+2.
  - With instr_ready held at 1, throughput is one instruction per cycle after the initial fill.
- Redirect (has priority over everything except reset). At the edge ending a cycle with redirect = 1:
  - fetch_pc <= redirect_address; count and pointers cleared; inflight <= 0, so the in-flight word is discarded.
  - No pop occurs. The core must not treat a word presented in the redirect cycle as accepted.
  - If redirect is asserted in cycle R: instr_valid = 0 in R+1 and R+2; the word at redirect_address is valid in R+3.
- Back-to-back redirects: each one restarts the sequence; only the last target is fetched.
- Wrap: a PC of 2^ADDR_WIDTH-1 is followed by 0; no flag or stall is generated.
- instr_ready while instr_valid = 0 has no effect.

Test Plan:
- Setup: ROM model with 1-cycle latency, mem[i] = 16'h1000 + i.
- 1. Release reset, instr_ready = 1 → rom_address = 0 during reset; instr_valid first rises 2 cycles after release; addresses 0,1,2,3… with data 1000,1001,1002,1003…; one per cycle, no gaps.
- 2. instr_ready = 0 from reset → buffer_count reaches 4 (addresses 0–3); fetch_pc stalls at 4; instr_data holds 16'h1000. Then raise ready → addresses 0..9 in order, with no duplicates or gaps.
- 3. FIFO full, ready = 0, pulse redirect to 0x123 for one cycle → instr_valid = 0 for 2 cycles; then address 0x123 with data 16'h1123; the old entries 1–3 never reappear.
- 4. Redirect to 0x7FE, ready = 1 → address sequence 7FE, 7FF, 000, 001 with data 17FE, 17FF, 1000, 1001.
- 5. Redirect and instr_ready both asserted with instr_valid = 1 → no pop counted; the next valid word is the target. Then redirects in two consecutive cycles (0x010 then 0x020) → the first valid address is 0x020.
- 6. Drop reset_n asynchronously mid-stream, between clock edges → instr_valid and buffer_count go to 0 without a clock edge; rom_address = 0; after release, fetch restarts from address 0.
